ahbl_apb_bridge_n: RTL and testbench

Parametrised AHB-Lite slave to multi-slot APB3 master bridge, the successor to the single-slave BFM bridge. Decodes up to 16 APB slots from HADDR and inserts APB wait states from per-slot PREADY. Converts per-slot PSLVERR, and accesses to unmapped slots, into the AHB two-cycle ERROR response. All bus outputs are registered; APB runs on the AHB clock.

---
 rtl/ahbl_apb_pkg.sv | 22 ++
 rtl/ahbl_apb_rmux.sv | 32 +++
 rtl/ahbl_apb_bridge_n.sv | 158 +++++++++++++++
 tb/tb_ahbl_apb_bridge_n.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_apb_pkg.sv
// ahbl_apb_pkg: shared AHB-Lite encodings and the bridge FSM states
// for the AHB-Lite to multi-slot APB3 bridge.
package ahbl_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_t;

endpackage

// File: rtl/ahbl_apb_rmux.sv
// ahbl_apb_rmux: selects the addressed slot's PRDATA/PREADY/PSLVERR.
// An index with no slot behind it completes at once with an error.
module ahbl_apb_rmux
    import ahbl_apb_pkg::*;
#(
    parameter int APB_SLOTS  = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]                      i_slot,
    input  logic [APB_SLOTS*DATA_WIDTH-1:0] i_prdata_s,
    input  logic [APB_SLOTS-1:0]            i_pready_s,
    input  logic [APB_SLOTS-1:0]            i_pslverr_s,
    output logic [DATA_WIDTH-1:0]           o_prdata,
    output logic                            o_pready,
    output logic                            o_pslverr
);

    // Route the registered slot's response; default is ready+error
    always_comb begin
        o_prdata  = '0;
        o_pready  = 1'b1;
        o_pslverr = 1'b1;
        for (int i = 0; i < APB_SLOTS; i++) begin
            if (i_slot == 4'(i)) begin
                o_prdata  = i_prdata_s[i*DATA_WIDTH +: DATA_WIDTH];
                o_pready  = i_pready_s[i];
                o_pslverr = i_pslverr_s[i];
            end
        end
    end

endmodule

// File: rtl/ahbl_apb_bridge_n.sv
// ahbl_apb_bridge_n: AHB-Lite slave to multi-slot APB3 master bridge.
// Optional ACCESS watchdog: define AHBL_APB_BRIDGE_TIMEOUT_EN.
module ahbl_apb_bridge_n
    import ahbl_apb_pkg::*;
#(
    parameter int APB_SLOTS      = 16,
    parameter int SLOT_LSB       = 12,
    parameter int PADDR_WIDTH    = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                            HCLK,
    input  logic                            HRESETN,
    input  logic                            HSEL,
    input  logic [31:0]                     HADDR,
    input  logic [1:0]                      HTRANS,
    input  logic                            HWRITE,
    input  logic [2:0]                      HSIZE,
    input  logic [DATA_WIDTH-1:0]           HWDATA,
    input  logic                            HREADYIN,
    output logic                            HREADYOUT,
    output logic                            HRESP,
    output logic [DATA_WIDTH-1:0]           HRDATA,
    output logic [PADDR_WIDTH-1:0]          PADDR,
    output logic [APB_SLOTS-1:0]            PSEL,
    output logic                            PENABLE,
    output logic                            PWRITE,
    output logic [DATA_WIDTH-1:0]           PWDATA,
    input  logic [APB_SLOTS*DATA_WIDTH-1:0] PRDATA_S,
    input  logic [APB_SLOTS-1:0]            PREADY_S,
    input  logic [APB_SLOTS-1:0]            PSLVERR_S
);

    logic [3:0]            w_hslot;
    logic                  w_accept;
    logic                  w_mapped;
    logic [APB_SLOTS-1:0]  w_hsel_oh;
    logic [DATA_WIDTH-1:0] w_prdata;
    logic                  w_pready;
    logic                  w_pslverr;
    logic                  w_unused;
    state_t                r_state;
    logic [3:0]            r_slot;
`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
    logic [15:0]           r_to_cnt;
    logic                  w_to_hit;

    assign w_to_hit = (r_to_cnt == 16'(TIMEOUT_CYCLES - 1));
`endif

    assign w_hslot  = HADDR[SLOT_LSB+3:SLOT_LSB];
    assign w_accept = HSEL & HREADYIN & HTRANS[1];
    assign w_mapped = ({1'b0, w_hslot} < 5'(APB_SLOTS));
    assign w_unused = ^{HSIZE, HADDR, HTRANS[0], 16'(TIMEOUT_CYCLES)};

    // One-hot PSEL pattern for the slot in the current address phase
    always_comb begin
        w_hsel_oh = '0;
        for (int i = 0; i < APB_SLOTS; i++) begin
            w_hsel_oh[i] = (w_hslot == 4'(i));
        end
    end

    ahbl_apb_rmux #(
        .APB_SLOTS  (APB_SLOTS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rmux (
        .i_slot      (r_slot),
        .i_prdata_s  (PRDATA_S),
        .i_pready_s  (PREADY_S),
        .i_pslverr_s (PSLVERR_S),
        .o_prdata    (w_prdata),
        .o_pready    (w_pready),
        .o_pslverr   (w_pslverr)
    );

    // Bridge FSM; every AHB and APB output is a register
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state   <= ST_IDLE;
            r_slot    <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= HRESP_OKAY;
                    r_state   <= ST_IDLE;
                    if (w_accept) begin
                        HREADYOUT <= 1'b0;
                        if (w_mapped) begin
                            r_state <= ST_SETUP;
                            r_slot  <= w_hslot;
                            PSEL    <= w_hsel_oh;
                            PADDR   <= HADDR[PADDR_WIDTH-1:0];
                            PWRITE  <= HWRITE;
`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
                            r_to_cnt <= '0;
`endif
                        end else begin
                            r_state <= ST_ERR1;
                            HRESP   <= HRESP_ERROR;
                        end
                    end
                end
                ST_SETUP: begin
                    PWDATA  <= HWDATA;
                    PENABLE <= 1'b1;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (w_pready) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        if (w_pslverr) begin
                            HRESP   <= HRESP_ERROR;
                            r_state <= ST_ERR1;
                        end else begin
                            if (!PWRITE) begin
                                HRDATA <= w_prdata;
                            end
                            HREADYOUT <= 1'b1;
                            r_state   <= ST_DONE;
                        end
                    end
`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
                    else if (w_to_hit) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        HRESP   <= HRESP_ERROR;
                        r_state <= ST_ERR1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 16'd1;
                    end
`endif
                end
                ST_ERR1: begin
                    HREADYOUT <= 1'b1;
                    r_state   <= ST_ERR2;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahbl_apb_bridge_n.sv
// tb_ahbl_apb_bridge_n: random AHB traffic against a cycle-count and
// memory reference model, with a configurable APB slave per slot.
module tb_ahbl_apb_bridge_n;
    import ahbl_apb_pkg::*;

    localparam int SLOTS = 6;
    localparam int DW    = 32;
    localparam int TO    = 16;

    typedef struct {
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        int          waits;
        bit          err;
        int          gap;
    } txn_t;

    logic                HCLK;
    logic                HRESETN;
    logic                HSEL;
    logic [31:0]         HADDR;
    logic [1:0]          HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [DW-1:0]       HWDATA;
    logic                HREADYIN;
    logic                HREADYOUT;
    logic                HRESP;
    logic [DW-1:0]       HRDATA;
    logic [11:0]         PADDR;
    logic [SLOTS-1:0]    PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [DW-1:0]       PWDATA;
    logic [SLOTS*DW-1:0] PRDATA_S;
    logic [SLOTS-1:0]    PREADY_S;
    logic [SLOTS-1:0]    PSLVERR_S;

    int n_chk = 0;
    int n_err = 0;

    int          cur_slot = 0;
    int          cur_wait = 0;
    bit          cur_err  = 1'b0;
    int          acc_cnt  = 0;
    logic        sel_rdy;
    logic [31:0] slave_mem [8][16];
    logic [31:0] exp_mem   [8][16];
    logic [31:0] exp_rdata;
    logic [SLOTS-1:0]    noise_rdy;
    logic [SLOTS-1:0]    noise_err;
    logic [SLOTS*DW-1:0] noise_dat;
    txn_t q[$];

    ahbl_apb_bridge_n #(
        .APB_SLOTS      (SLOTS),
        .SLOT_LSB       (12),
        .PADDR_WIDTH    (12),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .HCLK      (HCLK),
        .HRESETN   (HRESETN),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADYIN  (HREADYIN),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA_S  (PRDATA_S),
        .PREADY_S  (PREADY_S),
        .PSLVERR_S (PSLVERR_S)
    );

    assign HREADYIN = HREADYOUT;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] a, input bit w,
                                input logic [31:0] d, input int wt,
                                input bit e, input int g);
        txn_t t;
        t.addr  = a;
        t.wr    = w;
        t.wdata = d;
        t.waits = wt;
        t.err   = e;
        t.gap   = g;
        return t;
    endfunction

    // APB slave: selected slot waits cur_wait cycles; others are noise
    always_comb sel_rdy = (acc_cnt >= cur_wait);

    always_comb begin
        PREADY_S  = noise_rdy;
        PSLVERR_S = noise_err;
        PRDATA_S  = noise_dat;
        for (int i = 0; i < SLOTS; i++) begin
            if (i == cur_slot) begin
                PREADY_S[i]          = sel_rdy;
                PSLVERR_S[i]         = cur_err;
                PRDATA_S[i*DW +: DW] = slave_mem[i][PADDR[5:2]];
            end
        end
    end

    always @(posedge HCLK) begin
        noise_rdy <= SLOTS'($urandom);
        noise_err <= SLOTS'($urandom);
        for (int i = 0; i < SLOTS; i++) noise_dat[i*DW +: DW] <= $urandom;
        if (PENABLE && !sel_rdy) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (PENABLE && sel_rdy && PWRITE && !cur_err && cur_slot < SLOTS)
            slave_mem[cur_slot][PADDR[5:2]] <= PWDATA;
    end

    task automatic drive_idle();
        HSEL   = 1'($urandom);
        HTRANS = HSEL ? {1'b0, 1'($urandom)} : 2'($urandom);
        HADDR  = $urandom;
        HWRITE = 1'($urandom);
    endtask

    // Runs queue q as a pipelined AHB master; called at posedge+1
    task automatic run_q();
        int   ai, gapc, low, cyc, slot, off, acc, erre, win, exp_low;
        bit   ap_v, dp_v, rdy, prev_resp, mapped, to_en;
        txn_t dp;
        logic [31:0] exp_psel;
`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
        to_en = 1'b1;
`else
        to_en = 1'b0;
`endif
        ai = 0; low = 0; cyc = 0;
        ap_v = 0; dp_v = 0; prev_resp = 0;
        dp = mk(0, 0, 0, 0, 0, 0);
        gapc = (q.size() > 0) ? q[0].gap : 0;
        while ((ai < q.size() || ap_v || dp_v) && cyc < 5000) begin
            cyc++;
            if (!ap_v && ai < q.size()) begin
                if (gapc > 0) gapc--;
                else ap_v = 1;
            end
            if (ap_v) begin
                HSEL   = 1'b1;
                HTRANS = HTRANS_NONSEQ;
                HADDR  = q[ai].addr;
                HWRITE = q[ai].wr;
            end else begin
                drive_idle();
            end
            HWDATA = dp_v ? dp.wdata : $urandom;
            @(negedge HCLK);
            rdy = HREADYOUT;
            if (dp_v) begin
                slot   = int'(dp.addr[15:12]);
                off    = int'(dp.addr[5:2]);
                mapped = (slot < SLOTS);
                if (!mapped) begin
                    acc = 0; erre = 1;
                end else if (to_en && dp.waits >= TO) begin
                    acc = TO; erre = 1;
                end else begin
                    acc = dp.waits + 1; erre = int'(dp.err);
                end
                exp_low  = mapped ? 1 + acc + erre : 1;
                win      = mapped ? 1 + acc : 0;
                exp_psel = (low < win) ? (32'd1 << slot) : 32'd0;
                chk("psel", 32'(PSEL), exp_psel);
                chk("penable", 32'(PENABLE), 32'(low >= 1 && low < win));
                if (low < win) begin
                    chk("paddr", 32'(PADDR), 32'(dp.addr[11:0]));
                    chk("pwrite", 32'(PWRITE), 32'(dp.wr));
                    if (low >= 1 && dp.wr)
                        chk("pwdata", PWDATA, dp.wdata);
                end
                if (!rdy) begin
                    low++;
                    prev_resp = HRESP;
                end else begin
                    chk("lowcyc", 32'(low), 32'(exp_low));
                    chk("hresp", 32'(HRESP), 32'(erre));
                    chk("hresp_w", 32'(prev_resp), 32'(erre));
                    if (erre == 0) begin
                        if (dp.wr) exp_mem[slot][off] = dp.wdata;
                        else exp_rdata = exp_mem[slot][off];
                    end
                    chk("hrdata", HRDATA, exp_rdata);
                    dp_v = 0;
                end
            end else begin
                chk("idle_rdy", 32'(HREADYOUT), 32'd1);
                chk("idle_resp", 32'(HRESP), 32'd0);
                chk("idle_psel", 32'(PSEL), 32'd0);
            end
            @(posedge HCLK);
            #1;
            if (ap_v && rdy) begin
                dp       = q[ai];
                ai++;
                ap_v     = 0;
                dp_v     = 1;
                low      = 0;
                prev_resp = 0;
                cur_slot = int'(dp.addr[15:12]);
                cur_wait = dp.waits;
                cur_err  = dp.err;
                gapc     = (ai < q.size()) ? q[ai].gap : 0;
            end
        end
        chk("run_done", 32'(ai + int'(ap_v) + int'(dp_v)), 32'(q.size()));
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        q.delete();
    endtask

    initial begin
        logic [31:0] v;
        HRESETN = 1'b0;
        HSEL    = 1'b0;
        HTRANS  = HTRANS_IDLE;
        HADDR   = '0;
        HWRITE  = 1'b0;
        HSIZE   = 3'b010;
        HWDATA  = '0;
        exp_rdata = '0;
        for (int s = 0; s < 8; s++) begin
            for (int o = 0; o < 16; o++) begin
                v = $urandom;
                slave_mem[s][o] = v;
                exp_mem[s][o]   = v;
            end
        end
        slave_mem[5][1] = 32'hCAFE_F00D;
        exp_mem[5][1]   = 32'hCAFE_F00D;

        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_rdy", 32'(HREADYOUT), 32'd1);
        chk("rst_resp", 32'(HRESP), 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_pen", 32'(PENABLE), 32'd0);
        chk("rst_pwrite", 32'(PWRITE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        @(posedge HCLK);
        #1 HRESETN = 1'b1;

        q.push_back(mk(32'h0000_3010, 1, 32'h1234_5678, 0, 0, 1));
        q.push_back(mk(32'h0000_5004, 0, 32'h0, 3, 0, 1));
        q.push_back(mk(32'h0000_2000, 1, 32'hDEAD_BEEF, 0, 1, 1));
        q.push_back(mk(32'h0000_7000, 0, 32'h0, 0, 0, 1));
        q.push_back(mk(32'h0000_0008, 1, 32'hA5A5_5A5A, 0, 0, 1));
        q.push_back(mk(32'h0000_0008, 0, 32'h0, 0, 0, 0));
        q.push_back(mk(32'h0000_3010, 0, 32'h0, 1, 0, 0));
        run_q();

        cur_slot = 1;
        cur_wait = 50;
        cur_err  = 1'b0;
        HSEL   = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HADDR  = 32'h0000_1000;
        HWRITE = 1'b0;
        @(posedge HCLK);
        #1;
        HSEL   = 1'b0;
        HTRANS = HTRANS_IDLE;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("pre_rst_pen", 32'(PENABLE), 32'd1);
        #1 HRESETN = 1'b0;
        #1;
        chk("arst_psel", 32'(PSEL), 32'd0);
        chk("arst_pen", 32'(PENABLE), 32'd0);
        chk("arst_rdy", 32'(HREADYOUT), 32'd1);
        chk("arst_resp", 32'(HRESP), 32'd0);
        chk("arst_hrdata", HRDATA, 32'd0);
        exp_rdata = '0;
        cur_wait  = 0;
        @(posedge HCLK);
        #1 HRESETN = 1'b1;

        for (int n = 0; n < 60; n++) begin
            v = {16'($urandom), 4'($urandom_range(0, 7)), 6'($urandom),
                 4'($urandom), 2'b00};
            q.push_back(mk(v, 1'($urandom), $urandom, $urandom_range(0, 3),
                           ($urandom_range(0, 5) == 0),
                           ($urandom_range(0, 2) == 0) ?
                               $urandom_range(1, 2) : 0));
        end
        run_q();

`ifdef AHBL_APB_BRIDGE_TIMEOUT_EN
        q.push_back(mk(32'h0000_1020, 1, 32'h0BAD_0BAD, 40, 0, 1));
        q.push_back(mk(32'h0000_1020, 0, 32'h0, 0, 0, 0));
        run_q();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
